// File: rtl/cpu_launch_ctrl.sv
// Purpose : loads a program image into instruction memory, seeds two argument
//           registers, runs the CPU until HALT and reads two result registers back.
// Latency : imem write same cycle as the accepted word; result_valid 3 cycles after HALT.
// Backpr. : i_ld_valid/o_ld_ready handshake, ready held high for the whole LOAD phase.
//
// Optional feature macro: CPU_LAUNCH_WATCHDOG_EN (run-cycle watchdog, limit WDOG_CYCLES).
//
// Ports:
//   i_clk, i_rst_n                 clock (rising edge), asynchronous active-low reset
//   i_start, i_arg                 launch pulse (IDLE only) and 64-bit argument
//   i_ld_valid/o_ld_ready,
//   i_ld_data, i_ld_last           program word stream
//   o_imem_we/addr/wdata           instruction memory write port
//   o_rf_we/addr/wdata, i_rf_rdata register-file backdoor (read is combinational)
//   o_cpu_rst, o_cpu_hold          processor reset / clock-enable inhibit
//   i_cpu_cstate                   processor control state (HALT detection)
//   o_busy, o_result_valid,
//   o_result, o_err                status and captured 64-bit result
module cpu_launch_ctrl #(
  parameter int unsigned IMEM_AW     = 8,
  parameter logic [3:0]  HALT_STATE  = 4'b1110,
  parameter logic [4:0]  ARG_HI_REG  = 5'd1,
  parameter logic [4:0]  ARG_LO_REG  = 5'd2,
  parameter int unsigned WDOG_CYCLES = 65535
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic [63:0]        i_arg,
  input  logic               i_ld_valid,
  output logic               o_ld_ready,
  input  logic [31:0]        i_ld_data,
  input  logic               i_ld_last,
  output logic               o_imem_we,
  output logic [IMEM_AW-1:0] o_imem_addr,
  output logic [31:0]        o_imem_wdata,
  output logic               o_rf_we,
  output logic [4:0]         o_rf_addr,
  output logic [31:0]        o_rf_wdata,
  input  logic [31:0]        i_rf_rdata,
  output logic               o_cpu_rst,
  output logic               o_cpu_hold,
  input  logic [3:0]         i_cpu_cstate,
  output logic               o_busy,
  output logic               o_result_valid,
  output logic [63:0]        o_result,
  output logic               o_err
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_SEED_HI = 3'd2,
    S_SEED_LO = 3'd3,
    S_RUN     = 3'd4,
    S_READ_HI = 3'd5,
    S_READ_LO = 3'd6
  } state_t;

  localparam logic [16:0] WDOG_LIMIT = 17'(WDOG_CYCLES);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [63:0]          r_arg;
  logic [IMEM_AW-1:0]   r_imem_addr;
  logic [63:0]          r_result;
  logic                 r_result_valid;
  logic                 r_err;

  logic                 w_start_acc;   // start accepted this cycle
  logic                 w_ld_acc;      // program word accepted this cycle
  logic                 w_overflow;    // accepted word filled the last address without ld_last
  logic                 w_halt;        // CPU reports HALT while running
  logic                 w_wdog_trip;   // run-cycle limit reached this cycle
  logic                 w_wdog_fire;   // watchdog actually ends the run (HALT has priority)

  // ---------------------------------------------------------------------------
  // Run watchdog
  // ---------------------------------------------------------------------------
`ifdef CPU_LAUNCH_WATCHDOG_EN
  logic [16:0] r_wdog_cnt;
  logic [16:0] w_wdog_inc;

  assign w_wdog_inc  = r_wdog_cnt + 17'd1;
  // r_wdog_cnt holds the number of RUN cycles already completed, so the
  // WDOG_LIMIT-th RUN cycle is the last one.
  assign w_wdog_trip = (w_wdog_inc == WDOG_LIMIT);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wdog_cnt <= '0;
    end else if (r_state == S_SEED_LO) begin
      // cleared on the way into RUN
      r_wdog_cnt <= '0;
    end else if (r_state == S_RUN) begin
      r_wdog_cnt <= w_wdog_inc;
    end
  end
`else
  // No watchdog: RUN only ends on HALT. The limit stays referenced so the
  // parameter list is identical in both builds.
  assign w_wdog_trip = 1'b0 && (WDOG_LIMIT != 17'd0);
`endif

  // ---------------------------------------------------------------------------
  // Next-state and per-state outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt  = r_state;
    w_start_acc  = 1'b0;
    w_ld_acc     = 1'b0;
    w_overflow   = 1'b0;
    w_halt       = 1'b0;
    w_wdog_fire  = 1'b0;
    o_ld_ready   = 1'b0;
    o_imem_we    = 1'b0;
    o_imem_wdata = '0;
    o_rf_we      = 1'b0;
    o_rf_addr    = '0;
    o_rf_wdata   = '0;
    o_cpu_rst    = 1'b1;
    o_cpu_hold   = 1'b1;

    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_start_acc = 1'b1;
          w_state_nxt = S_LOAD;
        end
      end

      S_LOAD: begin
        o_ld_ready = 1'b1;
        if (i_ld_valid) begin
          w_ld_acc     = 1'b1;
          o_imem_we    = 1'b1;
          o_imem_wdata = i_ld_data;
          if (i_ld_last) begin
            w_state_nxt = S_SEED_HI;
          end else if (&r_imem_addr) begin
            // Image larger than imem: keep this word, abandon the launch.
            w_overflow  = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end

      S_SEED_HI: begin
        o_cpu_rst   = 1'b0;
        o_rf_we     = 1'b1;
        o_rf_addr   = ARG_HI_REG;
        o_rf_wdata  = r_arg[63:32];
        w_state_nxt = S_SEED_LO;
      end

      S_SEED_LO: begin
        o_cpu_rst   = 1'b0;
        o_rf_we     = 1'b1;
        o_rf_addr   = ARG_LO_REG;
        o_rf_wdata  = r_arg[31:0];
        w_state_nxt = S_RUN;
      end

      S_RUN: begin
        // CPU keeps its clock in the HALT cycle itself; hold resumes next cycle.
        o_cpu_rst  = 1'b0;
        o_cpu_hold = 1'b0;
        if (i_cpu_cstate == HALT_STATE) begin
          w_halt      = 1'b1;
          w_state_nxt = S_READ_HI;
        end else if (w_wdog_trip) begin
          w_wdog_fire = 1'b1;
          w_state_nxt = S_READ_HI;
        end
      end

      S_READ_HI: begin
        o_cpu_rst   = 1'b0;
        o_rf_addr   = ARG_HI_REG;
        w_state_nxt = S_READ_LO;
      end

      S_READ_LO: begin
        o_cpu_rst   = 1'b0;
        o_rf_addr   = ARG_LO_REG;
        w_state_nxt = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_arg          <= '0;
      r_imem_addr    <= '0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
      r_err          <= 1'b0;
    end else begin
      // Pulses in the first IDLE cycle after the low half has been captured.
      r_result_valid <= (r_state == S_READ_LO);

      if (w_start_acc) begin
        r_arg       <= i_arg;
        r_err       <= 1'b0;
        r_imem_addr <= '0;
      end

      if (w_ld_acc) begin
        r_imem_addr <= r_imem_addr + IMEM_AW'(1);
      end

      if (w_overflow || w_wdog_fire) begin
        r_err <= 1'b1;
      end

      if (r_state == S_READ_HI) begin
        r_result[63:32] <= i_rf_rdata;
      end

      if (r_state == S_READ_LO) begin
        r_result[31:0] <= i_rf_rdata;
      end
    end
  end

  assign o_imem_addr    = r_imem_addr;
  assign o_busy         = (r_state != S_IDLE);
  assign o_result_valid = r_result_valid;
  assign o_result       = r_result;
  assign o_err          = r_err;

  // w_halt only documents the RUN exit condition for waveform debug.
  logic w_unused;
  assign w_unused = w_halt;

endmodule

// File: tb/tb_cpu_launch_ctrl.sv
module tb_cpu_launch_ctrl;

  localparam logic [3:0] HALT = 4'b1110;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [63:0] arg;
  logic        ld_valid;
  logic        ld_ready;
  logic [31:0] ld_data;
  logic        ld_last;
  logic        imem_we;
  logic [1:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_wdata;
  logic [31:0] rf_rdata;
  logic        cpu_rst;
  logic        cpu_hold;
  logic [3:0]  cstate;
  logic        busy;
  logic        result_valid;
  logic [63:0] result;
  logic        err;

  cpu_launch_ctrl #(
    .IMEM_AW    (2),
    .HALT_STATE (HALT),
    .ARG_HI_REG (5'd1),
    .ARG_LO_REG (5'd2),
    .WDOG_CYCLES(50)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_start       (start),
    .i_arg         (arg),
    .i_ld_valid    (ld_valid),
    .o_ld_ready    (ld_ready),
    .i_ld_data     (ld_data),
    .i_ld_last     (ld_last),
    .o_imem_we     (imem_we),
    .o_imem_addr   (imem_addr),
    .o_imem_wdata  (imem_wdata),
    .o_rf_we       (rf_we),
    .o_rf_addr     (rf_addr),
    .o_rf_wdata    (rf_wdata),
    .i_rf_rdata    (rf_rdata),
    .o_cpu_rst     (cpu_rst),
    .o_cpu_hold    (cpu_hold),
    .i_cpu_cstate  (cstate),
    .o_busy        (busy),
    .o_result_valid(result_valid),
    .o_result      (result),
    .o_err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file and CPU model plus event counters.
  logic [31:0] rf [32];
  int cyc        = 0;
  int halt_cyc   = 0;
  int rv_cnt     = 0;
  int imem_cnt   = 0;
  int rfwe_cnt   = 0;
  int run_cnt    = 0;
  int run_target = 0;   // 0: CPU never halts
  logic [31:0] res_hi = '0;
  logic [31:0] res_lo = '0;

  assign rf_rdata = rf[rf_addr];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (result_valid) rv_cnt <= rv_cnt + 1;
    if (imem_we) imem_cnt <= imem_cnt + 1;
    if (rf_we) begin
      rfwe_cnt    <= rfwe_cnt + 1;
      rf[rf_addr] <= rf_wdata;
    end
    if (cpu_rst) begin
      run_cnt <= 0;
      cstate  <= 4'h0;
    end else if (!cpu_hold) begin
      if (cstate == HALT) halt_cyc <= cyc;
      run_cnt <= run_cnt + 1;
      if (run_cnt + 1 == run_target) begin
        cstate <= HALT;
        rf[1]  <= res_hi;
        rf[2]  <= res_lo;
      end
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  // Waits (bounded) for result_valid; returns positioned inside the pulse cycle.
  task automatic wait_rv(input string tag);
    int n;
    n = 0;
    settle();
    while (!result_valid && n < 3000) begin
      tick();
      settle();
      n++;
    end
    chk({tag, "_rv_seen"}, 64'(result_valid), 64'd1);
  endtask

  int s_imem, s_rfwe, s_rv, n_run;

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    arg      = '0;
    ld_valid = 1'b0;
    ld_data  = '0;
    ld_last  = 1'b0;

    // ---------------- reset state ----------------
    #3;
    chk("rst_cpu_rst",  64'(cpu_rst), 64'd1);
    chk("rst_cpu_hold", 64'(cpu_hold), 64'd1);
    chk("rst_busy",     64'(busy), 64'd0);
    chk("rst_ld_ready", 64'(ld_ready), 64'd0);
    chk("rst_err",      64'(err), 64'd0);
    chk("rst_rv",       64'(result_valid), 64'd0);
    chk("rst_result",   result, 64'd0);
    chk("rst_imem_addr", 64'(imem_addr), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // ---------------- RC5-style run, ld_valid toggling ----------------
    run_target = 20;
    res_hi     = 32'hCA8F6958;
    res_lo     = 32'h6D786F53;
    s_imem     = imem_cnt;
    s_rfwe     = rfwe_cnt;
    s_rv       = rv_cnt;
    start = 1'b1;
    arg   = 64'h0101010101010101;
    tick();
    start = 1'b0;
    settle();
    chk("t1_busy",     64'(busy), 64'd1);
    chk("t1_ld_ready", 64'(ld_ready), 64'd1);
    chk("t1_cpu_rst",  64'(cpu_rst), 64'd1);
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'b0;
      settle();
      chk("t1_idle_gap_we", 64'(imem_we), 64'd0);
      tick();
      ld_valid = 1'b1;
      ld_data  = 32'h11111111 * (i + 1);
      ld_last  = (i == 3);
      settle();
      chk("t1_we",    64'(imem_we), 64'd1);
      chk("t1_addr",  64'(imem_addr), 64'(i));
      chk("t1_wdata", 64'(imem_wdata), 64'(32'h11111111 * (i + 1)));
      tick();
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    settle();
    chk("t1_sh_rf_we",   64'(rf_we), 64'd1);
    chk("t1_sh_rf_addr", 64'(rf_addr), 64'd1);
    chk("t1_sh_wdata",   64'(rf_wdata), 64'h01010101);
    chk("t1_sh_cpu_rst", 64'(cpu_rst), 64'd0);
    chk("t1_sh_hold",    64'(cpu_hold), 64'd1);
    chk("t1_sh_ready",   64'(ld_ready), 64'd0);
    tick();
    settle();
    chk("t1_sl_rf_addr", 64'(rf_addr), 64'd2);
    chk("t1_sl_wdata",   64'(rf_wdata), 64'h01010101);
    tick();
    settle();
    chk("t1_run_hold",  64'(cpu_hold), 64'd0);
    chk("t1_run_rf_we", 64'(rf_we), 64'd0);
    chk("t1_seed_r1",   64'(rf[1]), 64'h01010101);
    // start while busy is ignored
    start = 1'b1;
    arg   = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    start = 1'b0;
    wait_rv("t1");
    chk("t1_result",  result, 64'hca8f69586d786f53);
    chk("t1_latency", 64'(cyc - halt_cyc), 64'd3);
    tick();
    settle();
    chk("t1_rv_pulse", 64'(result_valid), 64'd0);
    chk("t1_busy_end", 64'(busy), 64'd0);
    chk("t1_cpu_rst_end", 64'(cpu_rst), 64'd1);
    chk("t1_rv_count",   64'(rv_cnt - s_rv), 64'd1);
    chk("t1_imem_count", 64'(imem_cnt - s_imem), 64'd4);
    chk("t1_rfwe_count", 64'(rfwe_cnt - s_rfwe), 64'd2);

    // ---------------- factorial run ----------------
    run_target = 5;
    res_hi     = 32'h0;
    res_lo     = 32'd479001600;
    start = 1'b1;
    arg   = {32'h0, 32'd12};
    tick();
    start    = 1'b0;
    ld_valid = 1'b1;
    ld_data  = 32'hDEADBEEF;
    ld_last  = 1'b1;
    settle();
    chk("t2_addr0", 64'(imem_addr), 64'd0);
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    tick();
    tick();
    settle();
    chk("t2_seed_r2", 64'(rf[2]), 64'd12);
    wait_rv("t2");
    chk("t2_result",  result, 64'h00000000_1C8CFC00);
    chk("t2_latency", 64'(cyc - halt_cyc), 64'd3);

    // ---------------- overflow, start in the result_valid cycle ----------------
    start = 1'b1;
    arg   = 64'h0;
    tick();
    start = 1'b0;
    settle();
    chk("t3_start_acc", 64'(busy), 64'd1);
    chk("t3_rv_low",    64'(result_valid), 64'd0);
    s_imem = imem_cnt;
    s_rfwe = rfwe_cnt;
    s_rv   = rv_cnt;
    for (int i = 0; i < 5; i++) begin
      ld_valid = 1'b1;
      ld_last  = 1'b0;
      ld_data  = 32'hA0 + 32'(i);
      settle();
      if (i < 4) begin
        chk("t3_we",   64'(imem_we), 64'd1);
        chk("t3_addr", 64'(imem_addr), 64'(i));
      end else begin
        chk("t3_no_wrap_we", 64'(imem_we), 64'd0);
        chk("t3_ready_low",  64'(ld_ready), 64'd0);
        chk("t3_err",        64'(err), 64'd1);
        chk("t3_busy",       64'(busy), 64'd0);
      end
      tick();
    end
    ld_valid = 1'b0;
    settle();
    chk("t3_imem_count", 64'(imem_cnt - s_imem), 64'd4);
    chk("t3_no_rf_we",   64'(rfwe_cnt - s_rfwe), 64'd0);
    chk("t3_no_rv",      64'(rv_cnt - s_rv), 64'd0);
    chk("t3_result_hold", result, 64'h00000000_1C8CFC00);

    // ---------------- reset mid-RUN ----------------
    run_target = 0;
    start = 1'b1;
    arg   = 64'h12345678_87654321;
    tick();
    start = 1'b0;
    settle();
    chk("t4_err_cleared", 64'(err), 64'd0);
    for (int i = 0; i < 2; i++) begin
      ld_valid = 1'b1;
      ld_data  = 32'hB0 + 32'(i);
      ld_last  = (i == 1);
      tick();
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    repeat (7) tick();
    settle();
    chk("t4_in_run", 64'(cpu_hold), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("t4_cpu_rst",  64'(cpu_rst), 64'd1);
    chk("t4_cpu_hold", 64'(cpu_hold), 64'd1);
    chk("t4_busy",     64'(busy), 64'd0);
    chk("t4_addr_rst", 64'(imem_addr), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start    = 1'b0;
    ld_valid = 1'b1;
    ld_data  = 32'hC0C0C0C0;
    ld_last  = 1'b1;
    settle();
    chk("t4_reload_we",   64'(imem_we), 64'd1);
    chk("t4_reload_addr", 64'(imem_addr), 64'd0);
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    tick();
    tick();
    settle();

    // ---------------- CPU never halts ----------------
`ifdef CPU_LAUNCH_WATCHDOG_EN
    n_run = 0;
    while (!cpu_hold && n_run < 2000) begin
      n_run++;
      tick();
      settle();
    end
    chk("t5_run_cycles", 64'(n_run), 64'd50);
    chk("t5_wdog_err",   64'(err), 64'd1);
    wait_rv("t5");
    chk("t5_result", result, 64'h12345678_87654321);
    tick();
    settle();
    chk("t5_busy_end", 64'(busy), 64'd0);
`else
    n_run = 0;
    repeat (1000) begin
      if (!cpu_hold) n_run++;
      tick();
    end
    settle();
    chk("t5_run_cycles", 64'(n_run), 64'd1000);
    chk("t5_still_run",  64'(cpu_hold), 64'd0);
    chk("t5_busy",       64'(busy), 64'd1);
    chk("t5_no_err",     64'(err), 64'd0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
